// File: rtl/ex_stage.sv
// RV64 execute stage: ALU, branch target, EX/MEM register, optional multiplier.
// Define EX_MUL_EN to build the iterative shift-add multiplier and its stall logic.
module ex_stage #(
    parameter int XLEN       = 64,
    parameter int MUL_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] ReadData1,
    input  logic [XLEN-1:0] ReadData2,
    input  logic [XLEN-1:0] imm_data,
    input  logic [4:0]      rd,
    input  logic [3:0]      Funct,
    input  logic [1:0]      ALUOp,
    input  logic            is_mul,
    input  logic            ALUSrc,
    input  logic            Branch,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            Regwrite,
    input  logic            MemtoReg,
    input  logic            flush,
    output logic            stall_out,
    output logic            valid_out,
    output logic [XLEN-1:0] ALU_result_out,
    output logic            Zero_out,
    output logic [XLEN-1:0] PC_branch_out,
    output logic [XLEN-1:0] WriteData_out,
    output logic [4:0]      rd_out,
    output logic            Branch_out,
    output logic            MemRead_out,
    output logic            MemWrite_out,
    output logic            Regwrite_out,
    output logic            MemtoReg_out
);

    localparam int SW = $clog2(XLEN);

    if (MUL_CYCLES != XLEN) begin : g_bad_cfg
        $error("ex_stage: MUL_CYCLES must equal XLEN");
    end

    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] ex_res;
    logic [SW-1:0]   shamt;
    logic [3:0]      fn;
    logic            slt;
    logic            capture;

    assign op_b  = ALUSrc ? imm_data : ReadData2;
    assign shamt = op_b[SW-1:0];
    assign slt   = $signed(ReadData1) < $signed(op_b);

    // I-type has no SUB; bit 30 only distinguishes SRAI from SRLI.
    always_comb begin
        fn = Funct;
        if (ALUOp == 2'b11 && Funct[2:0] != 3'b101)
            fn[3] = 1'b0;
    end

    always_comb begin
        alu_res = '0;
        case (ALUOp)
            2'b00: alu_res = ReadData1 + op_b;
            2'b01: alu_res = ReadData1 - op_b;
            default: begin
                case (fn)
                    4'b0000: alu_res = ReadData1 + op_b;
                    4'b1000: alu_res = ReadData1 - op_b;
                    4'b0001: alu_res = ReadData1 << shamt;
                    4'b0010: alu_res = {{(XLEN-1){1'b0}}, slt};
                    4'b0100: alu_res = ReadData1 ^ op_b;
                    4'b0101: alu_res = ReadData1 >> shamt;
                    4'b1101: alu_res = XLEN'($signed(ReadData1) >>> shamt);
                    4'b0110: alu_res = ReadData1 | op_b;
                    4'b0111: alu_res = ReadData1 & op_b;
                    default: alu_res = '0;
                endcase
            end
        endcase
    end

`ifdef EX_MUL_EN
    localparam int CW = $clog2(MUL_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic            mul_start;
    logic            last_step;

    assign mul_start = in_valid & is_mul & ~flush;
    assign last_step = (count == CW'(MUL_CYCLES - 1));

    always_comb begin
        state_nx  = state;
        stall_out = in_valid & is_mul & (state != DONE) & ~flush;
        case (state)
            IDLE: if (mul_start) state_nx = BUSY;
            BUSY: begin
                if (flush)
                    state_nx = IDLE;
                else if (last_step)
                    state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && mul_start) begin
                mcand  <= ReadData1;
                mplier <= op_b;
                acc    <= '0;
                count  <= '0;
            end else if (state == BUSY) begin
                if (mplier[0])
                    acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
            end
        end
    end

    assign ex_res = is_mul ? acc : alu_res;
`else
    assign stall_out = 1'b0;
    assign ex_res    = is_mul ? '0 : alu_res;
`endif

    assign capture = in_valid & ~flush & ~stall_out;

    // Anything not captured is a bubble with every field zeroed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out      <= 1'b0;
            ALU_result_out <= '0;
            Zero_out       <= 1'b0;
            PC_branch_out  <= '0;
            WriteData_out  <= '0;
            rd_out         <= '0;
            Branch_out     <= 1'b0;
            MemRead_out    <= 1'b0;
            MemWrite_out   <= 1'b0;
            Regwrite_out   <= 1'b0;
            MemtoReg_out   <= 1'b0;
        end else if (capture) begin
            valid_out      <= 1'b1;
            ALU_result_out <= ex_res;
            Zero_out       <= (ex_res == '0);
            PC_branch_out  <= PC + (imm_data << 1);
            WriteData_out  <= ReadData2;
            rd_out         <= rd;
            Branch_out     <= Branch;
            MemRead_out    <= MemRead;
            MemWrite_out   <= MemWrite;
            Regwrite_out   <= Regwrite;
            MemtoReg_out   <= MemtoReg;
        end else begin
            valid_out      <= 1'b0;
            ALU_result_out <= '0;
            Zero_out       <= 1'b0;
            PC_branch_out  <= '0;
            WriteData_out  <= '0;
            rd_out         <= '0;
            Branch_out     <= 1'b0;
            MemRead_out    <= 1'b0;
            MemWrite_out   <= 1'b0;
            Regwrite_out   <= 1'b0;
            MemtoReg_out   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed ALU, branch, bubble, reset and MUL vectors.
// Each cycle's expected outputs and stall are queued and checked by a negedge monitor.
module tb_ex_stage;

    typedef struct packed {
        logic        v;
        logic [63:0] res;
        logic        z;
        logic [63:0] pcb;
        logic [63:0] wd;
        logic [4:0]  rd;
        logic [4:0]  ctl;
    } out_t;

    typedef struct {
        logic        v;
        logic [63:0] pc;
        logic [63:0] r1;
        logic [63:0] r2;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [3:0]  fn;
        logic [1:0]  op;
        logic        mul;
        logic        src;
        logic [4:0]  ctl;
        logic        fl;
    } in_t;

    typedef struct {
        out_t  o;
        logic  st;
        string tag;
    } item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] PC, ReadData1, ReadData2, imm_data;
    logic [4:0]  rd;
    logic [3:0]  Funct;
    logic [1:0]  ALUOp;
    logic        is_mul, ALUSrc, Branch, MemRead, MemWrite, Regwrite, MemtoReg;
    logic        flush;
    logic        stall_out, valid_out, Zero_out;
    logic [63:0] ALU_result_out, PC_branch_out, WriteData_out;
    logic [4:0]  rd_out;
    logic        Branch_out, MemRead_out, MemWrite_out, Regwrite_out, MemtoReg_out;

    int    checks = 0;
    int    passed = 0;
    item_t q[$];
    out_t  prev;
    out_t  bub;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .PC(PC),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .imm_data(imm_data),
        .rd(rd), .Funct(Funct), .ALUOp(ALUOp), .is_mul(is_mul),
        .ALUSrc(ALUSrc), .Branch(Branch), .MemRead(MemRead),
        .MemWrite(MemWrite), .Regwrite(Regwrite), .MemtoReg(MemtoReg),
        .flush(flush), .stall_out(stall_out), .valid_out(valid_out),
        .ALU_result_out(ALU_result_out), .Zero_out(Zero_out),
        .PC_branch_out(PC_branch_out), .WriteData_out(WriteData_out),
        .rd_out(rd_out), .Branch_out(Branch_out), .MemRead_out(MemRead_out),
        .MemWrite_out(MemWrite_out), .Regwrite_out(Regwrite_out),
        .MemtoReg_out(MemtoReg_out)
    );

    task automatic chk(input string tag, input out_t e, input logic est);
        out_t a;
        a = '{valid_out, ALU_result_out, Zero_out, PC_branch_out,
              WriteData_out, rd_out,
              {Branch_out, MemRead_out, MemWrite_out, Regwrite_out, MemtoReg_out}};
        checks++;
        if (a === e && stall_out === est)
            passed++;
        else
            $display("FAIL %s: got out=%h stall=%b, want out=%h stall=%b",
                     tag, a, stall_out, e, est);
    endtask

    always @(negedge clk) begin
        item_t it;
        if (q.size() > 0) begin
            it = q.pop_front();
            chk(it.tag, it.o, it.st);
        end
    end

    function automatic in_t idle();
        in_t i;
        i = '{v: 1'b0, pc: '0, r1: '0, r2: '0, imm: '0, rd: '0, fn: '0,
              op: '0, mul: 1'b0, src: 1'b0, ctl: '0, fl: 1'b0};
        return i;
    endfunction

    function automatic in_t rr(input logic [63:0] a, input logic [63:0] b,
                               input logic [3:0] f, input logic [1:0] op);
        in_t i;
        i     = idle();
        i.v   = 1'b1;
        i.pc  = 64'h40;
        i.r1  = a;
        i.r2  = b;
        i.rd  = 5'd3;
        i.fn  = f;
        i.op  = op;
        i.ctl = 5'b00010;
        return i;
    endfunction

    function automatic in_t ri(input logic [63:0] a, input logic [63:0] im,
                               input logic [3:0] f);
        in_t i;
        i     = rr(a, 64'h77, f, 2'b11);
        i.imm = im;
        i.src = 1'b1;
        return i;
    endfunction

    function automatic out_t done(input in_t i, input logic [63:0] r);
        out_t o;
        o = '{1'b1, r, (r == 64'd0), i.pc + (i.imm << 1), i.r2, i.rd, i.ctl};
        return o;
    endfunction

    task automatic drive(input in_t i);
        in_valid  = i.v;
        PC        = i.pc;
        ReadData1 = i.r1;
        ReadData2 = i.r2;
        imm_data  = i.imm;
        rd        = i.rd;
        Funct     = i.fn;
        ALUOp     = i.op;
        is_mul    = i.mul;
        ALUSrc    = i.src;
        {Branch, MemRead, MemWrite, Regwrite, MemtoReg} = i.ctl;
        flush     = i.fl;
    endtask

    // Present one instruction for a cycle; queue the registered outputs
    // expected from the previous cycle together with this cycle's stall.
    task automatic cyc(input in_t i, input out_t nx, input logic st,
                       input string tag);
        item_t it;
        @(posedge clk);
        #1;
        drive(i);
        it.o   = prev;
        it.st  = st;
        it.tag = tag;
        q.push_back(it);
        prev = nx;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #1;
        reset = 1'b1;
        drive(idle());
        #1;
        chk(tag, bub, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        prev  = bub;
    endtask

    task automatic mul_seq(input in_t m, input logic [63:0] r, input string tag);
        for (int k = 0; k <= 64; k++)
            cyc(m, bub, 1'b1, tag);
        cyc(m, done(m, r), 1'b0, tag);
    endtask

    initial begin
        in_t i;
        in_t m;
        bub   = '0;
        prev  = '0;
        reset = 1'b1;
        drive(idle());
        #2;
        chk("reset_state", bub, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        i = rr(64'd5, 64'd7, 4'b0000, 2'b10);
        cyc(i, done(i, 64'd12), 1'b0, "add");

        i = rr(64'h1234, 64'h1234, 4'b0000, 2'b01);
        i.pc = 64'h100; i.imm = 64'd8; i.ctl = 5'b10000;
        cyc(i, '{1'b1, 64'd0, 1'b1, 64'h110, 64'h1234, 5'd3, 5'b10000},
            1'b0, "beq");

        i = ri(64'h8000_0000_0000_0000, 64'd4, 4'b1101);
        cyc(i, done(i, 64'hF800_0000_0000_0000), 1'b0, "srai");

        i = rr(64'd3, 64'd5, 4'b1000, 2'b10);
        cyc(i, done(i, 64'hFFFF_FFFF_FFFF_FFFE), 1'b0, "sub");

        i = rr(64'd1, 64'd63, 4'b0001, 2'b10);
        cyc(i, done(i, 64'h8000_0000_0000_0000), 1'b0, "sll63");

        i = rr(64'd1, 64'd68, 4'b0001, 2'b10);
        cyc(i, done(i, 64'd16), 1'b0, "sll_shamt6");

        i = rr(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 2'b10);
        cyc(i, done(i, 64'd1), 1'b0, "slt_neg");

        i = rr(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, 2'b10);
        cyc(i, done(i, 64'd0), 1'b0, "slt_pos");

        i = rr(64'hF0F0, 64'h0FF0, 4'b0100, 2'b10);
        cyc(i, done(i, 64'hFF00), 1'b0, "xor");

        i = rr(64'h8000_0000_0000_0000, 64'd4, 4'b0101, 2'b10);
        cyc(i, done(i, 64'h0800_0000_0000_0000), 1'b0, "srl");

        i = rr(64'h8000_0000_0000_0010, 64'd4, 4'b1101, 2'b10);
        cyc(i, done(i, 64'hF800_0000_0000_0001), 1'b0, "sra");

        i = rr(64'hF000, 64'h000F, 4'b0110, 2'b10);
        cyc(i, done(i, 64'hF00F), 1'b0, "or");

        i = rr(64'hFF0F, 64'h0FF0, 4'b0111, 2'b10);
        cyc(i, done(i, 64'h0F00), 1'b0, "and");

        i = rr(64'd9, 64'd9, 4'b0011, 2'b10);
        cyc(i, done(i, 64'd0), 1'b0, "bad_funct");

        i = ri(64'd10, 64'd5, 4'b1000);
        cyc(i, done(i, 64'd15), 1'b0, "addi_bit30");

        i = ri(64'h8000_0000_0000_0000, 64'd4, 4'b0101);
        cyc(i, done(i, 64'h0800_0000_0000_0000), 1'b0, "srli");

        i = rr(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000, 2'b00);
        i.ctl = 5'b01001;
        cyc(i, done(i, 64'd0), 1'b0, "add_wrap");

        i = rr(64'd2, 64'd3, 4'b0000, 2'b10);
        i.v = 1'b0; i.ctl = 5'b11111;
        cyc(i, bub, 1'b0, "invalid");

        i = rr(64'd2, 64'd3, 4'b0000, 2'b10);
        i.fl = 1'b1;
        cyc(i, bub, 1'b0, "flush");

        i = rr(64'd20, 64'd22, 4'b0000, 2'b10);
        cyc(i, done(i, 64'd42), 1'b0, "add_pre_rst");
        cyc(idle(), bub, 1'b0, "idle");
        do_reset("reset_async");

        m = rr(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 4'b0000, 2'b10);
        m.mul = 1'b1;
`ifdef EX_MUL_EN
        mul_seq(m, 64'hFFFF_FFFF_FFFF_FFFD, "mul");
        mul_seq(m, 64'hFFFF_FFFF_FFFF_FFFD, "mul_b2b");

        for (int k = 0; k <= 10; k++)
            cyc(m, bub, 1'b1, "mul_pre_flush");
        i = m;
        i.fl = 1'b1;
        cyc(i, bub, 1'b0, "mul_flush");
        i = rr(64'd5, 64'd7, 4'b0000, 2'b10);
        cyc(i, done(i, 64'd12), 1'b0, "add_after_flush");

        for (int k = 0; k <= 30; k++)
            cyc(m, bub, 1'b1, "mul_pre_rst");
        do_reset("mul_reset_async");
        m.r1 = 64'd12345;
        m.r2 = 64'd6789;
        mul_seq(m, 64'd83810205, "mul_restart");
`else
        cyc(m, done(m, 64'd0), 1'b0, "mul_disabled");
        m.fl = 1'b1;
        cyc(m, bub, 1'b0, "mul_disabled_flush");
`endif
        i = rr(64'd1, 64'd2, 4'b0000, 2'b10);
        cyc(i, done(i, 64'd3), 1'b0, "add_last");
        cyc(idle(), bub, 1'b0, "drain");
        @(negedge clk);
        #1;
        checks++;
        if (q.size() == 0)
            passed++;
        else
            $display("FAIL drain: got %0d pending, want 0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
